// File: rtl/array_lane_fifo.sv
// Valid/ready FIFO carrying LANES x WIDTH words with per-lane write masking,
// optional lane reversal on output, a packed output view, occupancy and flush.

module array_lane_fifo_lane #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] wr_lane,
    input  logic             wr_keep,
    output logic [WIDTH-1:0] wr_masked,
    input  logic [WIDTH-1:0] rd_lane,
    input  logic             rd_valid,
    output logic [WIDTH-1:0] rd_out
);
    assign wr_masked = wr_lane & {WIDTH{wr_keep}};
    // Output is forced to zero whenever no head word is presented.
    assign rd_out    = rd_lane & {WIDTH{rd_valid}};
endmodule

module array_lane_fifo #(
    parameter int LANES   = 4,
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 4,
    parameter int REVERSE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data [LANES],
    input  logic [LANES-1:0]           in_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data [LANES],
    output logic [LANES*WIDTH-1:0]     out_packed,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef logic [LANES-1:0][WIDTH-1:0] word_t;

    word_t          mem [DEPTH];
    word_t          wr_word;
    word_t          head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic           clr;

    // Handshake flags come only from registered count, so no in->out comb paths.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign clr       = rst || flush;
    assign head      = mem[rd_ptr];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int SRC = (REVERSE != 0) ? (LANES - 1 - i) : i;
        array_lane_fifo_lane #(.WIDTH(WIDTH)) u_lane (
            .wr_lane   (in_data[i]),
            .wr_keep   (in_mask[i]),
            .wr_masked (wr_word[i]),
            .rd_lane   (head[SRC]),
            .rd_valid  (out_valid),
            .rd_out    (out_data[i])
        );
        assign out_packed[i*WIDTH +: WIDTH] = out_data[i];
    end

    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_array_lane_fifo.sv
// Randomised and directed bench for array_lane_fifo; a queue model of the
// stored words is checked every cycle against a normal and a reversed instance.

module tb_array_lane_fifo;
    localparam int LANES = 4;
    localparam int WIDTH = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data [LANES];
    logic [LANES-1:0] in_mask = '1;

    logic             in_ready, out_valid, in_ready_r, out_valid_r;
    logic [WIDTH-1:0] out_data [LANES];
    logic [WIDTH-1:0] out_data_r [LANES];
    logic [7:0]       out_packed, out_packed_r;
    logic [2:0]       count, count_r;

    int vectors = 0;
    int errors  = 0;
    bit mon_en  = 1'b0;
    logic [7:0] exp_q [$];

    array_lane_fifo #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .REVERSE(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_packed(out_packed), .count(count));

    array_lane_fifo #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .REVERSE(1)) dut_r (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_packed(out_packed_r), .count(count_r));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < LANES; i++) r[2*i +: 2] = w[2*(LANES-1-i) +: 2];
        return r;
    endfunction

    function automatic logic [7:0] masked_in();
        logic [7:0] r;
        for (int i = 0; i < LANES; i++) r[2*i +: 2] = in_mask[i] ? in_data[i] : 2'b00;
        return r;
    endfunction

    task automatic set_word(input logic [7:0] w);
        for (int i = 0; i < LANES; i++) in_data[i] = w[2*i +: 2];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid high with word w until it is accepted; leaves in_valid high.
    task automatic push(input logic [7:0] w);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        set_word(w);
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = in_ready;
            cyc();
        end
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 50 && count != 0; t++) cyc();
        chk("drain_count", count, 0);
        out_ready = 1'b0;
    endtask

    // Monitor: compare presented state with the model, then advance the model
    // by the handshakes that the coming edge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            int  sz;
            bit  full;
            sz = exp_q.size();
            full = (sz == DEPTH);
            chk("count", count, sz);
            chk("count_r", count_r, sz);
            chk("in_ready", in_ready, !full);
            chk("out_valid", out_valid, sz != 0);
            chk("out_valid_r", out_valid_r, sz != 0);
            if (sz != 0) begin
                chk("out_packed", out_packed, exp_q[0]);
                chk("out_packed_rev", out_packed_r, rev(exp_q[0]));
                for (int i = 0; i < LANES; i++) begin
                    chk("out_data_lane", out_data[i], exp_q[0][2*i +: 2]);
                    chk("out_data_rev_lane", out_data_r[i], exp_q[0][2*(LANES-1-i) +: 2]);
                end
            end else begin
                chk("out_packed_idle", out_packed, 0);
                chk("out_packed_rev_idle", out_packed_r, 0);
            end
            if (rst || flush) begin
                exp_q.delete();
            end else begin
                if (sz != 0 && out_ready) void'(exp_q.pop_front());
                if (in_valid && !full) exp_q.push_back(masked_in());
            end
        end
    end

    initial begin
        set_word(8'h00);
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_count", count, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_packed", out_packed, 0);
        mon_en = 1'b1;

        // Basic order
        push(8'hE4);
        push(8'h1B);
        push(8'hA5);
        in_valid = 1'b0;
        chk("basic_count3", count, 3);
        chk("basic_first_packed", out_packed, 8'hE4);
        drain();

        // Fill and overflow
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 4);
        set_word(8'h55);
        cyc();
        chk("held_count", count, 4);
        out_ready = 1'b1;
        chk("pop_cycle_in_ready", in_ready, 0);
        cyc();
        out_ready = 1'b0;
        chk("after_pop_count", count, 3);
        chk("after_pop_in_ready", in_ready, 1);
        cyc();
        chk("fifth_accepted_count", count, 4);
        drain();

        // Masking
        in_mask = 4'b0101;
        push(8'hFF);
        in_valid = 1'b0;
        in_mask = 4'hF;
        chk("mask_packed", out_packed, 8'h33);
        drain();

        // Reverse instance view
        push(8'hE4);
        in_valid = 1'b0;
        chk("reverse_packed", out_packed_r, 8'h1B);
        drain();

        // Streaming across pointer wraps
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_word(8'((k * 37 + 5) & 8'hFF));
            cyc();
            chk("stream_count", count, 1);
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_end_count", count, 0);
        out_ready = 1'b0;

        // Flush, then reset, mid-stream
        for (int pass = 0; pass < 2; pass++) begin
            push(8'h12); push(8'h34); push(8'h56);
            set_word(8'h78);
            if (pass == 0) flush = 1'b1; else rst = 1'b1;
            cyc();
            flush = 1'b0;
            rst = 1'b0;
            in_valid = 1'b0;
            chk("clr_count", count, 0);
            chk("clr_out_valid", out_valid, 0);
            chk("clr_in_ready", in_ready, 1);
            chk("clr_out_packed", out_packed, 0);
            for (int i = 0; i < LANES; i++) chk("clr_out_data", out_data[i], 0);
            cyc();
            chk("clr_dropped_count", count, 0);
        end

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_mask   = 4'($urandom);
            set_word(8'($urandom));
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 79) == 0);
            cyc();
        end
        flush = 1'b0;
        rst = 1'b0;
        drain();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
